// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: core and load-return requests in, register-file write out.
interface wb_port_arbiter_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
);
    logic              core_valid;
    logic              core_ready;
    logic [REG_AW-1:0] core_rd;
    logic              core_link;
    logic [XLEN-1:0]   core_alu_result;
    logic [XLEN-1:0]   core_pc_plus_4;

    logic              ld_valid;
    logic              ld_ready;
    logic [REG_AW-1:0] ld_rd;
    logic [XLEN-1:0]   ld_data;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [1:0]        wb_src;

    modport master (
        output core_valid, core_rd, core_link, core_alu_result, core_pc_plus_4,
        output ld_valid, ld_rd, ld_data,
        input  core_ready, ld_ready,
        input  rf_we, rf_waddr, rf_wdata, wb_src
    );

    modport slave (
        input  core_valid, core_rd, core_link, core_alu_result, core_pc_plus_4,
        input  ld_valid, ld_rd, ld_data,
        output core_ready, ld_ready,
        output rf_we, rf_waddr, rf_wdata, wb_src
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between core writeback and load return.
// Loads win by default; after MAX_LD_BURST loads that starve the core, the core gets one turn.
module wb_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned MAX_LD_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_LD_BURST + 1);

    typedef enum logic {
        LD_PRIO   = 1'b0,
        CORE_TURN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0] burst_cnt_inc;
    logic             core_ready_c, ld_ready_c;
    logic             core_xfer, ld_xfer;
    logic [XLEN-1:0]  core_wdata;
    logic [1:0]       core_src;

    assign bus.core_ready = core_ready_c;
    assign bus.ld_ready   = ld_ready_c;
    assign core_xfer      = bus.core_valid & core_ready_c;
    assign ld_xfer        = bus.ld_valid & ld_ready_c;
    assign burst_cnt_inc  = burst_cnt_q + CNT_W'(1);
    assign core_wdata     = bus.core_link ? bus.core_pc_plus_4 : bus.core_alu_result;
    assign core_src       = bus.core_link ? 2'b10 : 2'b00;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LD_PRIO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_PRIO: begin
                if (ld_xfer && bus.core_valid && (burst_cnt_inc == CNT_W'(MAX_LD_BURST))) begin
                    state_d = CORE_TURN;
                end
            end
            CORE_TURN: begin
                if (core_xfer || !bus.core_valid) begin
                    state_d = LD_PRIO;
                end
            end
        endcase
    end

    // Readies depend only on state and valids; held low throughout reset
    always_comb begin
        core_ready_c = 1'b0;
        ld_ready_c   = 1'b0;
        if (rst_n) begin
            case (state_q)
                LD_PRIO: begin
                    ld_ready_c   = bus.ld_valid;
                    core_ready_c = bus.core_valid & ~bus.ld_valid;
                end
                CORE_TURN: begin
                    core_ready_c = bus.core_valid;
                    ld_ready_c   = ~bus.core_valid & bus.ld_valid;
                end
            endcase
        end
    end

    // Counts loads granted while the core is waiting
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!bus.core_valid || core_xfer) begin
            burst_cnt_d = '0;
        end else if (ld_xfer) begin
            burst_cnt_d = burst_cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Registered write port; x0 writes update address/data/tag but never assert the enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.wb_src   <= 2'b00;
        end else if (ld_xfer) begin
            bus.rf_we    <= |bus.ld_rd;
            bus.rf_waddr <= bus.ld_rd;
            bus.rf_wdata <= bus.ld_data;
            bus.wb_src   <= 2'b01;
        end else if (core_xfer) begin
            bus.rf_we    <= |bus.core_rd;
            bus.rf_waddr <= bus.core_rd;
            bus.rf_wdata <= core_wdata;
            bus.wb_src   <= core_src;
        end else begin
            bus.rf_we    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed checks of wb_port_arbiter: reset, core-only, contention, starvation bound, x0, mid-op reset.
module tb_wb_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    wb_port_arbiter_if #(.XLEN(32), .REG_AW(5)) bus ();

    wb_port_arbiter #(
        .XLEN(32),
        .REG_AW(5),
        .MAX_LD_BURST(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_readies(input string tag, input logic exp_core, input logic exp_ld);
        #1;
        check({tag, ".core_ready"}, 32'(bus.core_ready), 32'(exp_core));
        check({tag, ".ld_ready"}, 32'(bus.ld_ready), 32'(exp_ld));
    endtask

    task automatic check_write(input string tag, input logic exp_we, input logic [4:0] exp_addr,
                               input logic [31:0] exp_data, input logic [1:0] exp_src);
        check({tag, ".rf_we"}, 32'(bus.rf_we), 32'(exp_we));
        check({tag, ".rf_waddr"}, 32'(bus.rf_waddr), 32'(exp_addr));
        check({tag, ".rf_wdata"}, bus.rf_wdata, exp_data);
        check({tag, ".wb_src"}, 32'(bus.wb_src), 32'(exp_src));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset with both sources requesting
        rst_n               = 1'b0;
        bus.core_valid      = 1'b1;
        bus.core_rd         = 5'd1;
        bus.core_link       = 1'b0;
        bus.core_alu_result = 32'h1111_1111;
        bus.core_pc_plus_4  = 32'h2222_2222;
        bus.ld_valid        = 1'b1;
        bus.ld_rd           = 5'd2;
        bus.ld_data         = 32'h3333_3333;
        tick();
        tick();
        check_readies("reset", 1'b0, 1'b0);
        check_write("reset", 1'b0, 5'd0, 32'h0, 2'b00);

        bus.core_valid = 1'b0;
        bus.ld_valid   = 1'b0;
        rst_n          = 1'b1;
        tick();
        check("idle.rf_we", 32'(bus.rf_we), 32'd0);

        // Core only, ALU result then link address
        bus.core_valid      = 1'b1;
        bus.core_rd         = 5'd5;
        bus.core_link       = 1'b0;
        bus.core_alu_result = 32'hDEAD_BEEF;
        bus.core_pc_plus_4  = 32'h0000_0104;
        check_readies("core_alu", 1'b1, 1'b0);
        tick();
        check_write("core_alu", 1'b1, 5'd5, 32'hDEAD_BEEF, 2'b00);
        bus.core_rd   = 5'd6;
        bus.core_link = 1'b1;
        check_readies("core_link", 1'b1, 1'b0);
        tick();
        check_write("core_link", 1'b1, 5'd6, 32'h0000_0104, 2'b10);
        bus.core_valid = 1'b0;
        tick();
        check_write("hold", 1'b0, 5'd6, 32'h0000_0104, 2'b10);

        // Simultaneous: load first, core next cycle
        bus.ld_valid        = 1'b1;
        bus.ld_rd           = 5'd3;
        bus.ld_data         = 32'h0000_1234;
        bus.core_valid      = 1'b1;
        bus.core_rd         = 5'd7;
        bus.core_link       = 1'b0;
        bus.core_alu_result = 32'h0000_CAFE;
        check_readies("simul_c0", 1'b0, 1'b1);
        tick();
        check_write("simul_ld", 1'b1, 5'd3, 32'h0000_1234, 2'b01);
        bus.ld_valid = 1'b0;
        check_readies("simul_c1", 1'b1, 1'b0);
        tick();
        check_write("simul_core", 1'b1, 5'd7, 32'h0000_CAFE, 2'b00);

        // Load flood: exactly four loads, then the core's turn, then loads resume
        bus.ld_valid        = 1'b1;
        bus.ld_rd           = 5'd9;
        bus.ld_data         = 32'h0000_0055;
        bus.core_rd         = 5'd10;
        bus.core_alu_result = 32'h0000_0077;
        for (int i = 0; i < 4; i++) begin
            check_readies($sformatf("flood_ld%0d", i), 1'b0, 1'b1);
            tick();
            check_write($sformatf("flood_ld%0d", i), 1'b1, 5'd9, 32'h0000_0055, 2'b01);
        end
        check_readies("flood_turn", 1'b1, 1'b0);
        tick();
        check_write("flood_core", 1'b1, 5'd10, 32'h0000_0077, 2'b00);
        check_readies("flood_resume", 1'b0, 1'b1);
        tick();
        check_write("flood_resume", 1'b1, 5'd9, 32'h0000_0055, 2'b01);

        // Three more loads reach the burst limit again and enter the core turn
        for (int i = 0; i < 3; i++) begin
            check_readies($sformatf("refill%0d", i), 1'b0, 1'b1);
            tick();
        end
        check_readies("pre_rst_turn", 1'b1, 1'b0);

        // Reset during core turn: grant dropped, no write, back to load priority with cnt 0
        rst_n = 1'b0;
        check_readies("midrst", 1'b0, 1'b0);
        tick();
        check("midrst.rf_we", 32'(bus.rf_we), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_readies($sformatf("post_rst_ld%0d", i), 1'b0, 1'b1);
            tick();
            check_write($sformatf("post_rst_ld%0d", i), 1'b1, 5'd9, 32'h0000_0055, 2'b01);
        end
        check_readies("post_rst_turn", 1'b1, 1'b0);
        tick();
        check_write("post_rst_core", 1'b1, 5'd10, 32'h0000_0077, 2'b00);

        // Core write to x0: accepted, enable suppressed, address/data still update
        bus.ld_valid        = 1'b0;
        bus.core_valid      = 1'b1;
        bus.core_rd         = 5'd0;
        bus.core_link       = 1'b0;
        bus.core_alu_result = 32'h0000_FFFF;
        check_readies("x0", 1'b1, 1'b0);
        tick();
        check_write("x0", 1'b0, 5'd0, 32'h0000_FFFF, 2'b00);
        bus.core_valid = 1'b0;
        tick();
        check("x0_idle.rf_we", 32'(bus.rf_we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
